// File: rtl/s1494_cone_scheduler.sv
// Step controller for the s1494 next-state datapath: owns the v7..v12 state register and
// time-shares one external cone evaluator, committing all new state bits at once.
module s1494_cone_scheduler #(
   parameter int NBITS = 6,
   parameter int NIN   = 7,
   parameter int SEL_W = 3,
   parameter int TMO   = 15
) (
   input  logic             clock,
   input  logic             CLR,
   input  logic [NIN-1:0]   pi,
   input  logic             start,
   output logic             busy,
   output logic             cone_req,
   output logic [SEL_W-1:0] cone_sel,
   output logic [NIN-1:0]   cone_pi,
   output logic [NBITS-1:0] cone_state,
   input  logic             cone_ack,
   input  logic             cone_out,
   output logic [NBITS-1:0] state,
   output logic             done,
   output logic             err,
   input  logic             err_clr
);

   localparam int TW = $clog2(TMO + 1);

   typedef enum logic [1:0] {IDLE, EVAL, COMMIT, ABORT} fsm_t;

   fsm_t             r_fsm;
   fsm_t             w_fsmNext;
   logic [NBITS-1:0] r_state;
   logic [NBITS-1:0] r_nxt;
   logic [NIN-1:0]   r_piQ;
   logic [SEL_W-1:0] r_sel;
   logic [TW-1:0]    r_timer;
   logic             r_err;
   logic             w_lastSel;
   logic             w_timeout;

   assign w_lastSel = (r_sel == SEL_W'(NBITS - 1));
   assign w_timeout = (r_timer == TW'(TMO - 1));

   always_ff @(posedge clock or negedge CLR) begin
      if (!CLR) r_fsm <= IDLE;
      else      r_fsm <= w_fsmNext;
   end

   // The TMO-th consecutive cycle without an ack aborts the step.
   always_comb begin
      w_fsmNext = r_fsm;
      busy      = 1'b0;
      cone_req  = 1'b0;
      done      = 1'b0;
      case (r_fsm)
         IDLE: begin
            if (start) w_fsmNext = EVAL;
         end
         EVAL: begin
            busy     = 1'b1;
            cone_req = 1'b1;
            if (cone_ack) begin
               if (w_lastSel) w_fsmNext = COMMIT;
            end else if (w_timeout) begin
               w_fsmNext = ABORT;
            end
         end
         COMMIT: begin
            busy      = 1'b1;
            done      = 1'b1;
            w_fsmNext = IDLE;
         end
         ABORT: begin
            busy      = 1'b1;
            w_fsmNext = IDLE;
         end
         default: w_fsmNext = IDLE;
      endcase
   end

   // Results collect in a shadow register so every cone sees the same old state.
   always_ff @(posedge clock or negedge CLR) begin
      if (!CLR) begin
         r_state <= '0;
         r_nxt   <= '0;
         r_piQ   <= '0;
         r_sel   <= '0;
         r_timer <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_fsm)
            IDLE: begin
               if (err_clr) r_err <= 1'b0;
               if (start) begin
                  r_piQ   <= pi;
                  r_sel   <= '0;
                  r_timer <= '0;
               end
            end
            EVAL: begin
               if (cone_ack) begin
                  r_nxt[r_sel] <= cone_out;
                  r_timer      <= '0;
                  if (!w_lastSel) r_sel <= r_sel + 1'b1;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            COMMIT: r_state <= r_nxt;
            ABORT:  r_err   <= 1'b1;
            default: ;
         endcase
      end
   end

   assign cone_sel   = r_sel;
   assign cone_pi    = r_piQ;
   assign cone_state = r_state;
   assign state      = r_state;
   assign err        = r_err;

endmodule

// File: tb/tb_s1494_cone_scheduler.sv
// Directed bench for s1494_cone_scheduler with a small behavioural cone unit that can
// return fixed bits or inverted old state, insert wait cycles, or stall one cone.
module tb_s1494_cone_scheduler;

   logic       clock = 1'b0;
   logic       CLR;
   logic [6:0] pi;
   logic       start;
   logic       busy;
   logic       coneReq;
   logic [2:0] coneSel;
   logic [6:0] conePi;
   logic [5:0] coneState;
   logic       coneAck;
   logic       coneOut;
   logic [5:0] state;
   logic       done;
   logic       err;
   logic       errClr;

   logic [5:0] retBits;
   logic       invertMode;
   int         ackDelay;
   int         waitCnt;
   logic [2:0] stallSel;

   int checkCount = 0;
   int errorCount = 0;

   s1494_cone_scheduler dut (
      .clock(clock), .CLR(CLR), .pi(pi), .start(start), .busy(busy),
      .cone_req(coneReq), .cone_sel(coneSel), .cone_pi(conePi), .cone_state(coneState),
      .cone_ack(coneAck), .cone_out(coneOut), .state(state), .done(done),
      .err(err), .err_clr(errClr)
   );

   always #5 clock = ~clock;

   // Cone unit: acks after ackDelay idle cycles, never acks stallSel (7 = no stall).
   assign coneAck = coneReq && (waitCnt >= ackDelay) && (coneSel != stallSel);
   assign coneOut = invertMode ? ~coneState[coneSel] : retBits[coneSel];

   always @(posedge clock) begin
      if (!coneReq || coneAck) waitCnt <= 0;
      else                     waitCnt <= waitCnt + 1;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Launches one step and waits (bounded) for done; returns the done cycle, start = cycle 0.
   task automatic applyStimulus(input logic [6:0] p, input logic clrErr, input int maxCyc,
                                input logic chkHold, input logic [5:0] holdState,
                                output int doneCyc);
      pi = p;
      start = 1'b1;
      errClr = clrErr;
      tick();
      start = 1'b0;
      errClr = 1'b0;
      checkOutput("firstSel", coneSel, 0);
      doneCyc = -1;
      for (int c = 1; c <= maxCyc; c++) begin
         if (done) begin
            doneCyc = c;
            break;
         end
         if (chkHold) begin
            checkOutput("holdState", coneState, holdState);
            checkOutput("holdPi", conePi, p);
         end
         tick();
      end
      if (doneCyc < 0) checkOutput("doneTimeout", 0, 1);
   endtask

   initial begin
      int doneCyc;
      int doneSeen;
      int errCyc;
      int c;

      CLR = 1'b0; pi = '0; start = 1'b0; errClr = 1'b0;
      retBits = '0; invertMode = 1'b0; ackDelay = 0; stallSel = 3'd7;
      tick(); tick();
      checkOutput("rstState", state, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstReq", coneReq, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstErr", err, 0);
      CLR = 1'b1;
      tick();

      // Single step, zero-wait acks, bits 1,0,1,1,0,0
      $display("[TB] single step");
      retBits = 6'b001101;
      pi = 7'h41; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         checkOutput("seqSel", coneSel, k - 1);
         checkOutput("seqReq", coneReq, 1);
         checkOutput("seqBusy", busy, 1);
         checkOutput("seqPi", conePi, 7'h41);
         checkOutput("seqDoneLow", done, 0);
         tick();
      end
      checkOutput("step1Done", done, 1);
      checkOutput("step1BusyCommit", busy, 1);
      tick();
      checkOutput("step1State", state, 6'b001101);
      checkOutput("step1BusyLow", busy, 0);
      checkOutput("step1DoneLow", done, 0);

      // Old-state isolation: first reach 3F, then invert it bit by bit
      $display("[TB] old-state isolation");
      retBits = 6'h3F;
      applyStimulus(7'h12, 1'b0, 20, 1'b0, 6'h00, doneCyc);
      tick();
      checkOutput("to3F", state, 6'h3F);
      invertMode = 1'b1;
      applyStimulus(7'h11, 1'b0, 20, 1'b1, 6'h3F, doneCyc);
      checkOutput("invDoneCyc", doneCyc, 7);
      tick();
      checkOutput("invState", state, 6'h00);
      invertMode = 1'b0;

      // Three wait cycles per cone
      $display("[TB] wait states");
      ackDelay = 3;
      retBits = 6'b101010;
      applyStimulus(7'h07, 1'b0, 40, 1'b1, 6'h00, doneCyc);
      checkOutput("waitDoneCyc", doneCyc, 25);
      checkOutput("waitErr", err, 0);
      tick();
      checkOutput("waitState", state, 6'b101010);
      ackDelay = 0;

      // Cone 2 never acks: ABORT in cycle 18, err visible from cycle 19
      $display("[TB] timeout");
      stallSel = 3'd2;
      retBits = 6'b000000;
      pi = 7'h33; start = 1'b1;
      tick();
      start = 1'b0;
      doneSeen = 0;
      errCyc = -1;
      for (int k = 1; k <= 30; k++) begin
         if (done) doneSeen++;
         if (err && errCyc < 0) errCyc = k;
         tick();
      end
      checkOutput("tmoErrCyc", errCyc, 19);
      checkOutput("tmoNoDone", doneSeen, 0);
      checkOutput("tmoState", state, 6'b101010);
      checkOutput("tmoIdle", busy, 0);
      stallSel = 3'd7;
      retBits = 6'b000111;
      applyStimulus(7'h44, 1'b1, 20, 1'b1, 6'b101010, doneCyc);
      checkOutput("clrErr", err, 0);
      checkOutput("clrDoneCyc", doneCyc, 7);
      tick();
      checkOutput("clrState", state, 6'b000111);

      // Reset asserted while cone 4 is being evaluated
      $display("[TB] reset mid-step");
      retBits = 6'b111111;
      pi = 7'h5A; start = 1'b1;
      tick();
      start = 1'b0;
      c = 0;
      while (coneSel != 3'd4 && c < 10) begin
         tick();
         c++;
      end
      checkOutput("reachCone4", coneSel, 4);
      #2;
      CLR = 1'b0;
      #1;
      checkOutput("midRstState", state, 0);
      checkOutput("midRstBusy", busy, 0);
      checkOutput("midRstReq", coneReq, 0);
      checkOutput("midRstSel", coneSel, 0);
      checkOutput("midRstPi", conePi, 0);
      checkOutput("midRstDone", done, 0);
      tick(); tick();
      checkOutput("midRstHeld", state, 0);
      CLR = 1'b1;
      tick();
      retBits = 6'b010011;
      applyStimulus(7'h66, 1'b0, 20, 1'b1, 6'h00, doneCyc);
      checkOutput("postRstDoneCyc", doneCyc, 7);
      tick();
      checkOutput("postRstState", state, 6'b010011);

      // start re-asserted in cycles 3 and 7, pi toggled while busy
      $display("[TB] start while busy");
      retBits = 6'b111000;
      pi = 7'h2A; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (k <= 7) checkOutput("busyPiHold", conePi, 7'h2A);
         if (k == 7) checkOutput("busyDone", done, 1);
         if (k == 8) checkOutput("busyIdle", busy, 0);
         start = (k == 3 || k == 7);
         pi = k[0] ? 7'h55 : 7'h2A;
         tick();
      end
      start = 1'b0;
      checkOutput("noSecondStep", busy, 0);
      checkOutput("noSecondReq", coneReq, 0);
      checkOutput("busyState", state, 6'b111000);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
